// File: rtl/lz77_pkg.sv
// Shared widths, state encoding and token layout for the LZ77 window decoder.
package lz77_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned OFF_W     = 6;
  localparam int unsigned LEN_W     = 6;
  localparam int unsigned WIN_DEPTH = 2 ** OFF_W;

  // One-hot, same encoding style as the compressor's controller.
  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StCopy = 4'b0010,
    StLit  = 4'b0100,
    StDone = 4'b1000
  } dec_state_e;

  typedef struct packed {
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] lit;
    logic              last;
  } lz77_tok_t;

  // A back-reference may only reach bytes already produced in this block.
  function automatic logic ref_illegal(lz77_tok_t tok, logic [OFF_W:0] fill);
    return (tok.length != '0) && ((tok.offset == '0) || ({1'b0, tok.offset} > fill));
  endfunction

endpackage

// File: rtl/lz77_hist_buf.sv
// 64-entry history window: write port at wr_ptr, asynchronous read port, fill count.
module lz77_hist_buf
  import lz77_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [OFF_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [OFF_W-1:0]  wr_ptr,
  output logic [OFF_W:0]    fill_cnt
);

  localparam logic [OFF_W:0] FillMax = (OFF_W + 1)'(WIN_DEPTH);

  logic [DATA_W-1:0] mem_q [WIN_DEPTH];
  logic [OFF_W-1:0]  wr_ptr_q;
  logic [OFF_W:0]    fill_cnt_q;

  // Contents are never reset; clearing the pointers is enough to start a block.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fill_cnt_q != FillMax) begin
        fill_cnt_q <= fill_cnt_q + 1'b1;
      end
    end
  end

  assign rd_data  = mem_q[rd_addr];
  assign wr_ptr   = wr_ptr_q;
  assign fill_cnt = fill_cnt_q;

endmodule

// File: rtl/lz77_window_decoder.sv
// LZ77 token decoder: replays back-references from a 64-byte window, one byte per cycle.
// Optional reference checking is enabled by defining LZ77_DEC_ERR_CHECK_EN.
module lz77_window_decoder
  import lz77_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [OFF_W-1:0]  tok_offset,
  input  logic [LEN_W-1:0]  tok_length,
  input  logic [DATA_W-1:0] tok_char,
  input  logic              tok_last,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              blk_done,
  output logic              err,
  output logic              busy
);

  dec_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_cnt_q, len_cnt_d;
  logic [DATA_W-1:0] char_q, char_d;
  logic              last_q, last_d;
  logic [OFF_W-1:0]  rd_ptr_q, rd_ptr_d;

  logic [DATA_W-1:0] rd_data;
  logic [OFF_W-1:0]  wr_ptr;
  logic [OFF_W:0]    fill_cnt;
  logic              hist_clr;
  logic              fire;
  lz77_tok_t         tok;

`ifdef LZ77_DEC_ERR_CHECK_EN
  logic err_q, err_d;
`endif

  assign tok  = '{offset: tok_offset, length: tok_length, lit: tok_char, last: tok_last};
  assign fire = out_valid & out_ready;

  lz77_hist_buf u_hist (
    .Clk      (Clk),
    .Rst      (Rst),
    .clr      (hist_clr),
    .wr_en    (fire),
    .wr_data  (out_data),
    .rd_addr  (rd_ptr_q),
    .rd_data  (rd_data),
    .wr_ptr   (wr_ptr),
    .fill_cnt (fill_cnt)
  );

  always_comb begin
    state_d   = state_q;
    len_cnt_d = len_cnt_q;
    char_d    = char_q;
    last_d    = last_q;
    rd_ptr_d  = rd_ptr_q;
    tok_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    blk_done  = 1'b0;
    hist_clr  = 1'b0;
`ifdef LZ77_DEC_ERR_CHECK_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          len_cnt_d = tok.length;
          char_d    = tok.lit;
          last_d    = tok.last;
          rd_ptr_d  = wr_ptr - tok.offset;
          state_d   = (tok.length != '0) ? StCopy : StLit;
`ifdef LZ77_DEC_ERR_CHECK_EN
          // Skip the copy but keep the literal/last so the stream stays aligned.
          if (ref_illegal(tok, fill_cnt)) begin
            err_d   = 1'b1;
            state_d = StLit;
          end
`endif
        end
      end
      StCopy: begin
        out_valid = 1'b1;
        out_data  = rd_data;
        if (out_ready) begin
          rd_ptr_d  = rd_ptr_q + 1'b1;
          len_cnt_d = len_cnt_q - 1'b1;
          if (len_cnt_q == LEN_W'(1)) begin
            state_d = StLit;
          end
        end
      end
      StLit: begin
        out_valid = 1'b1;
        out_data  = char_q;
        out_last  = last_q;
        if (out_ready) begin
          state_d = last_q ? StDone : StIdle;
        end
      end
      StDone: begin
        blk_done = 1'b1;
        hist_clr = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StIdle;
      len_cnt_q <= '0;
      char_q    <= '0;
      last_q    <= 1'b0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_cnt_q <= len_cnt_d;
      char_q    <= char_d;
      last_q    <= last_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

`ifdef LZ77_DEC_ERR_CHECK_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
  logic unused_fill;
  assign unused_fill = ^fill_cnt;
`endif

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_lz77_window_decoder.sv
// Directed self-checking bench for lz77_window_decoder.
module tb_lz77_window_decoder;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       tok_valid;
  logic       tok_ready;
  logic [5:0] tok_offset;
  logic [5:0] tok_length;
  logic [7:0] tok_char;
  logic       tok_last;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       out_last;
  logic       blk_done;
  logic       err;
  logic       busy;

  int n_cmp    = 0;
  int n_bad    = 0;
  int err_seen = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  logic [7:0] hist_m[$];
  logic [7:0] got[$];

  lz77_window_decoder dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .tok_offset (tok_offset),
    .tok_length (tok_length),
    .tok_char   (tok_char),
    .tok_last   (tok_last),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .blk_done   (blk_done),
    .err        (err),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

`ifndef LZ77_DEC_ERR_CHECK_EN
  always @(negedge Clk) if (mon_en && err !== 1'b0) err_seen++;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the decoder idle; returns just after a negedge, idle.
  task automatic send(input int off, input int len, input logic [7:0] ch, input bit last);
    logic [7:0] e;
    tok_valid  = 1'b1;
    tok_offset = 6'(off);
    tok_length = 6'(len);
    tok_char   = ch;
    tok_last   = last;
    chk("tok_ready", tok_ready, 1);
    @(negedge Clk);
    tok_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      e = hist_m[hist_m.size() - off];
      chk("copy_valid", out_valid, 1);
      chk("copy_data", out_data, e);
      chk("copy_last", out_last, 0);
      hist_m.push_back(e);
      got.push_back(out_data);
      @(negedge Clk);
    end
    chk("lit_valid", out_valid, 1);
    chk("lit_data", out_data, ch);
    chk("lit_last", out_last, last);
    hist_m.push_back(ch);
    got.push_back(out_data);
    @(negedge Clk);
    if (last) begin
      chk("blk_done", blk_done, 1);
      hist_m.delete();
      @(negedge Clk);
      chk("blk_done_pulse", blk_done, 0);
    end
    chk("idle_after", busy, 0);
  endtask

  task automatic check_got(input string tag, input string s);
    chk({tag, "_len"}, got.size(), s.len());
    for (int i = 0; i < s.len(); i++) begin
      chk($sformatf("%s[%0d]", tag, i), got[i], s[i]);
    end
    got.delete();
  endtask

  initial begin
    int start;
    Rst        = 1'b1;
    tok_valid  = 1'b0;
    tok_offset = '0;
    tok_length = '0;
    tok_char   = '0;
    tok_last   = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    chk("rst_tok_ready", tok_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_blk_done", blk_done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ptr", dut.u_hist.wr_ptr, 0);
    chk("rst_rd_ptr", dut.rd_ptr_q, 0);
    chk("rst_fill_cnt", dut.u_hist.fill_cnt, 0);
    mon_en = 1'b1;

    // Literal-only block: 5 cycles from first acceptance to idle after blk_done.
    start = cyc;
    send(0, 0, "A", 0);
    send(0, 0, "B", 1);
    chk("lit_cycles", cyc - start, 5);
    check_got("lit", "AB");

    // Plain back-reference.
    send(0, 0, "A", 0);
    send(0, 0, "B", 0);
    send(0, 0, "C", 0);
    send(3, 3, "D", 1);
    check_got("backref", "ABCABCD");

    // Overlapping copy reproduces a run.
    send(0, 0, "X", 0);
    send(1, 5, "Y", 1);
    check_got("overlap", "XXXXXXY");

    // 70 literals wrap wr_ptr; the copy reads bytes 67..70.
    for (int i = 1; i <= 70; i++) send(0, 0, 8'(i), 0);
    chk("wrap_fill_sat", dut.u_hist.fill_cnt, 64);
    chk("wrap_wr_ptr", dut.u_hist.wr_ptr, 6);
    send(4, 4, "Z", 1);
    chk("wrap_len", got.size(), 75);
    for (int k = 0; k < 4; k++) chk($sformatf("wrap_copy[%0d]", k), got[70 + k], 67 + k);
    chk("wrap_lit", got[74], "Z");
    got.delete();

    // Backpressure mid-copy, then reset while copying.
    send(0, 0, "P", 0);
    send(0, 0, "Q", 0);
    send(0, 0, "R", 0);
    tok_valid  = 1'b1;
    tok_offset = 6'd3;
    tok_length = 6'd3;
    tok_char   = "S";
    tok_last   = 1'b0;
    chk("bp_tok_ready", tok_ready, 1);
    @(negedge Clk);
    tok_valid = 1'b0;
    chk("bp_first", out_data, "P");
    out_ready = 1'b0;
    @(negedge Clk);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, "P");
    chk("bp_hold_wr_ptr", dut.u_hist.wr_ptr, 3);
    out_ready = 1'b1;
    @(negedge Clk);
    chk("bp_next", out_data, "Q");
    chk("bp_wr_ptr", dut.u_hist.wr_ptr, 4);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_blk_done", blk_done, 0);
    chk("mid_rst_tok_ready", tok_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fill_cnt", dut.u_hist.fill_cnt, 0);
    chk("mid_rst_wr_ptr", dut.u_hist.wr_ptr, 0);
    hist_m.delete();
    got.delete();

    send(0, 0, "K", 0);
    send(1, 2, "L", 1);
    check_got("post_rst", "KKKL");

`ifdef LZ77_DEC_ERR_CHECK_EN
    tok_valid  = 1'b1;
    tok_offset = 6'd2;
    tok_length = 6'd3;
    tok_char   = "Q";
    tok_last   = 1'b1;
    chk("err_tok_ready", tok_ready, 1);
    @(negedge Clk);
    tok_valid = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_lit_valid", out_valid, 1);
    chk("err_lit_data", out_data, "Q");
    chk("err_lit_last", out_last, 1);
    @(negedge Clk);
    chk("err_pulse_end", err, 0);
    chk("err_blk_done", blk_done, 1);
    @(negedge Clk);
    chk("err_idle", busy, 0);
`else
    chk("err_never", err_seen, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
